// File: rtl/qq_pkg.sv
// Shared constants and helpers for the quick-queue priority blocks.
// Ordering-mode encodings and the empty-slot key fill used by every level.
package qq_pkg;

    localparam int QQ_MIN_FIRST = 0;
    localparam int QQ_MAX_FIRST = 1;

    // Fill bit for an empty slot's key: all ones sorts last in min mode, all zeros in max mode.
    function automatic logic sentinel(input int max_first);
        return (max_first == QQ_MAX_FIRST) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/qq_prio_cmp.sv
// Combinational "new entry precedes stored entry" compare for one queue slot.
// Strict compare, so an equal key never precedes and lands after existing equals.
module qq_prio_cmp
    import qq_pkg::*;
#(
    parameter int KW        = 8,
    parameter int MAX_FIRST = QQ_MIN_FIRST
) (
    input  logic [KW-1:0] i_new_key,
    input  logic [KW-1:0] i_stored_key,
    output logic          o_precedes
);

    logic w_lt;
    logic w_gt;

    assign w_lt       = (i_new_key < i_stored_key);
    assign w_gt       = (i_new_key > i_stored_key);
    assign o_precedes = (MAX_FIRST == QQ_MAX_FIRST) ? w_gt : w_lt;

endmodule

// File: rtl/qq_shift_pq.sv
// D-entry sorted shift-register priority queue with single-cycle enqueue,
// dequeue and replace; head entry and status are registered outputs.
module qq_shift_pq
    import qq_pkg::*;
#(
    parameter int   KW        = 8,
    parameter int   PW        = 8,
    parameter int   D         = 4,
    parameter int   MAX_FIRST = QQ_MIN_FIRST,
    localparam int  CW        = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_i,
    input  logic [KW-1:0] key_i,
    input  logic [PW-1:0] data_i,
    input  logic          deq_i,
    output logic [KW-1:0] key_o,
    output logic [PW-1:0] data_o,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          ovf_o,
    output logic          udf_o
);

    typedef struct packed {
        logic          valid;
        logic [KW-1:0] key;
        logic [PW-1:0] payload;
    } entry_t;

    localparam logic [KW-1:0] SENT_KEY    = {KW{sentinel(MAX_FIRST)}};
    localparam entry_t        EMPTY_ENTRY = '{valid: 1'b0, key: SENT_KEY, payload: '0};

    entry_t        r_ent [D];
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_ovf;
    logic          r_udf;

    entry_t        w_new;
    entry_t        w_base [D];
    entry_t        w_ins  [D];
    entry_t        w_nxt  [D];
    logic [D-1:0]  w_prec;
    logic [D-1:0]  w_stay;
    logic [CW-1:0] w_count_nxt;
    logic          w_do_deq;
    logic          w_do_enq;
    logic          w_ovf;
    logic          w_udf;

    assign w_do_deq = deq_i & ~r_empty;
    assign w_do_enq = enq_i & (~r_full | w_do_deq);
    assign w_ovf    = enq_i & r_full & ~deq_i;
    assign w_udf    = deq_i & r_empty;

    always_comb begin
        w_new         = EMPTY_ENTRY;
        w_new.valid   = 1'b1;
        w_new.key     = key_i;
        w_new.payload = data_i;
    end

    // A replace is pop-then-insert: the insertion search runs on the already-popped array.
    always_comb begin
        for (int unsigned i = 0; i < D - 1; i++) begin
            w_base[i] = w_do_deq ? r_ent[i + 1] : r_ent[i];
        end
        w_base[D-1] = w_do_deq ? EMPTY_ENTRY : r_ent[D-1];
    end

    for (genvar g = 0; g < D; g++) begin : g_cmp
        qq_prio_cmp #(
            .KW       (KW),
            .MAX_FIRST(MAX_FIRST)
        ) u_cmp (
            .i_new_key   (key_i),
            .i_stored_key(w_base[g].key),
            .o_precedes  (w_prec[g])
        );
        assign w_stay[g] = w_base[g].valid & ~w_prec[g];
    end

    // w_stay is a thermometer: ones below the insertion point, zeros at and above it.
    always_comb begin
        w_ins[0] = w_stay[0] ? w_base[0] : w_new;
        for (int unsigned i = 1; i < D; i++) begin
            if (w_stay[i]) begin
                w_ins[i] = w_base[i];
            end else if (w_stay[i - 1]) begin
                w_ins[i] = w_new;
            end else begin
                w_ins[i] = w_base[i - 1];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < D; i++) begin
            w_nxt[i] = w_do_enq ? w_ins[i] : w_base[i];
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_enq, w_do_deq})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < D; i++) begin
                r_ent[i] <= EMPTY_ENTRY;
            end
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < D; i++) begin
                r_ent[i] <= w_nxt[i];
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(D));
            r_ovf   <= w_ovf;
            r_udf   <= w_udf;
        end
    end

    assign key_o  = r_ent[0].key;
    assign data_o = r_ent[0].payload;
    assign empty  = r_empty;
    assign full   = r_full;
    assign count  = r_count;
    assign ovf_o  = r_ovf;
    assign udf_o  = r_udf;

endmodule

// File: doc/qq_shift_pq.md
Name: qq_shift_pq

Overview:
- Parametrised successor to the quick-queue node: a self-contained D-entry priority queue holding key+payload pairs in a register array kept sorted at all times.
- Single-cycle enqueue, dequeue, or combined replace operation; head of queue always visible on the outputs.
- Selectable min-first or max-first ordering; FIFO-stable among equal keys; overflow and underflow reporting.
- Used as a leaf/level block in the quick-queue hierarchy and as a standalone scheduler queue.

Parameters:
- KW, 8, key width in bits.
- PW, 8, payload width in bits (>=1).
- D, 4, number of entries (>=2).
- MAX_FIRST, 0, ordering mode: 0 = smallest key at head, 1 = largest key at head.
- CW, $clog2(D+1), count width (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- enq_i  in  1  enqueue request, sampled on the clock edge.
- key_i  in  KW  key to enqueue.
- data_i  in  PW  payload to enqueue.
- deq_i  in  1  dequeue request (pop head), sampled on the clock edge.
- key_o  out  KW  head key (entry 0); sentinel when empty.
- data_o  out  PW  head payload; 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == D.
- count  out  CW  number of valid entries.
- ovf_o  out  1  one-cycle pulse: enqueue dropped.
- udf_o  out  1  one-cycle pulse: dequeue on empty ignored.

Behaviour:
- Reset (rst=0 at an edge): all entries invalid; key = sentinel (all ones if MAX_FIRST=0, all zeros if MAX_FIRST=1); payload 0; count=0; empty=1; full=0; ovf_o=0; udf_o=0. Reset overrides any enq_i/deq_i in the same cycle.
- Storage: entry[0..D-1] = {valid, key, payload}. Valid entries are contiguous from index 0.
- Ordering: "a precedes b" means a.key < b.key (MAX_FIRST=0) or a.key > b.key (MAX_FIRST=1). Equal keys keep arrival order, so the new entry goes after all existing equal keys.
- Outputs: key_o, data_o, empty, full and count are driven directly from registers. All effects are visible the cycle after the edge on which the operation is sampled (latency 1).
- Enqueue only (enq_i=1, deq_i=0, !full):
  - pos = number of valid entries that the new entry does not precede.
  - Entries at index >= pos shift up by one; the new entry is written at pos.
  - count increments.
- Dequeue only (deq_i=1, enq_i=0, !empty):
  - entry[i] <= entry[i+1] for all i.
  - entry[D-1] becomes invalid/sentinel.
  - count decrements.
- Enqueue+dequeue, !empty: the result equals popping the head and then inserting the new entry; count is unchanged. This is also permitted when full and never raises ovf_o.
- Enqueue+dequeue, empty: the dequeue is ignored and udf_o pulses; the enqueue proceeds normally (count=1).
- Enqueue when full without dequeue: storage and count are unchanged; ovf_o pulses for one cycle.
- Dequeue when empty without enqueue: no state change; udf_o pulses for one cycle.
- Neither request asserted: all state holds; ovf_o=0; udf_o=0.
- Keys equal to the sentinel value are legal data. Validity comes only from the valid bits, never from key comparison.
- No combinational path exists from any input to any output.

Decomposition:
- Package qq_pkg:
  - entry_t struct {valid, key, payload}, parametrised via localparams or a class wrapper per the team pattern.
  - Function sentinel(MAX_FIRST).
  - Ordering mode constants QQ_MIN_FIRST = 0, QQ_MAX_FIRST = 1.
- Sub-module qq_prio_cmp (KW, MAX_FIRST): combinational "new entry precedes stored entry" compare. Instantiated D times to form the thermometer code that locates the insertion point.

Test Plan:
- Reset then 4 enqueues of keys 30,10,20,40 (D=4, min mode; payloads 1..4) -> key_o sequence 30,10,10,10; count 1..4; full=1 after the 4th; 4 dequeues then yield keys 10,20,30,40 with payloads 2,3,1,4.
- Full queue {10,20,30,40} + enq key 5 alone -> ovf_o=1 for one cycle, contents unchanged; then enq 25 with deq -> head 20, contents {20,25,30,40}, count 4, no ovf_o.
- Empty queue: deq alone -> udf_o pulse, count 0; enq 7 + deq same cycle -> udf_o pulse, key_o=7, count 1.
- Stability: enq key 9 with payloads A,B,C in that order -> dequeues return payloads A,B,C.
- MAX_FIRST=1: enq 3,200,255,0 -> dequeue order 255,200,3,0; empty key_o=0. Min mode with enq key 255 -> valid entry, empty=0.
- Reset asserted mid-stream with enq_i=1 -> next cycle count=0, empty=1, key_o=sentinel, no ovf_o/udf_o.
